// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Data-memory responder for an RV32I MEM stage: single-outstanding request/response
// handshake with programmable access latency, byte/half/word lanes and error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic calc_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        illegal      = we ? (f3 > 3'd2) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = (addr[31:2] >= 30'(DEPTH_WORDS));
        return illegal || misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    logic        accept;
    logic        enter_resp;
    logic        eff_we;
    logic [2:0]  eff_f3;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [31:0] eff_wdata_sh;
    logic [3:0]  eff_be;
    logic        eff_err;
    logic        mem_we;
    logic [IDX_W-1:0] eff_idx;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0] rd_word;
    logic        cap_err;

    assign accept     = REQ_VALID && REQ_READY;
    assign enter_resp = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                        ((state == S_WAIT) && (cnt == 3'd0));

    // With zero wait cycles the commit happens on the accept edge itself, so the
    // live request is used there; otherwise the captured copy is.
    assign eff_we    = (state == S_IDLE) ? REQ_WE     : cap_we;
    assign eff_f3    = (state == S_IDLE) ? REQ_FUNCT3 : cap_f3;
    assign eff_addr  = (state == S_IDLE) ? REQ_ADDR   : cap_addr;
    assign eff_wdata = (state == S_IDLE) ? REQ_WDATA  : cap_wdata;

    assign eff_err      = calc_err(eff_we, eff_f3, eff_addr);
    assign eff_idx      = eff_addr[IDX_W+1:2];
    assign eff_wdata_sh = eff_wdata << {eff_addr[1:0], 3'b000};
    assign mem_we       = enter_resp && eff_we && !eff_err && !RST;

    always_comb begin
        eff_be = 4'b1111;
        case (eff_f3[1:0])
            2'b00:   eff_be = 4'b0001 << eff_addr[1:0];
            2'b01:   eff_be = 4'b0011 << eff_addr[1:0];
            default: eff_be = 4'b1111;
        endcase
    end

    assign cap_idx = cap_addr[IDX_W+1:2];
    assign rd_word = mem[cap_idx] >> {cap_addr[1:0], 3'b000};
    assign cap_err = calc_err(cap_we, cap_f3, cap_addr);

    // Storage has no reset; only enabled byte lanes are written.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) begin
                    mem[eff_idx][8*i +: 8] <= eff_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // RESP spends one cycle with RSP_VALID low while the response is registered,
    // giving an accept-to-valid latency of WAIT_CYCLES+1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'd0;
            RSP_ERR   <= 1'b0;
            cap_we    <= 1'b0;
            cap_f3    <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    REQ_READY <= 1'b1;
                    if (accept) begin
                        REQ_READY <= 1'b0;
                        cap_we    <= REQ_WE;
                        cap_f3    <= REQ_FUNCT3;
                        cap_addr  <= REQ_ADDR;
                        cap_wdata <= REQ_WDATA;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 3'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (!RSP_VALID) begin
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= cap_err;
                        RSP_RDATA <= (cap_err || cap_we) ? 32'd0 : load_ext(cap_f3, rd_word);
                    end else if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        RSP_RDATA <= 32'd0;
                        RSP_ERR   <= 1'b0;
                        REQ_READY <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    REQ_READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Directed bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=256) with
// hand-computed expected load results, error flags and handshake timing.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int failures;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_WE(req_we),
        .REQ_FUNCT3(req_funct3),
        .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid),
        .RSP_READY(rsp_ready),
        .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles RSP_READY stays low once the response is up.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
        req_wdata  = 32'hA5A5_A5A5;
        checkOutput({tag, "_ready_after_accept"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (rsp_valid) break;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
        checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            checkOutput({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({tag, "_valid_cleared"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;

        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready_low", 32'(req_ready), 32'd0);
        tick();
        checkOutput("rst_release_ready_high", 32'(req_ready), 32'd1);

        applyStimulus("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        applyStimulus("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus("sb_11",  1'b1, 3'b000, 32'h11, 32'h0000_0080, 0, 32'h0, 1'b0);
        applyStimulus("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 0, 32'hFFFF_FF80, 1'b0);
        applyStimulus("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 0, 32'h0000_0080, 1'b0);
        applyStimulus("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD_80EF, 1'b0);
        applyStimulus("sh_12",  1'b1, 3'b001, 32'h12, 32'h0000_1234, 0, 32'h0, 1'b0);
        applyStimulus("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h1234_80EF, 1'b0);
        applyStimulus("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 0, 32'h0000_1234, 1'b0);
        applyStimulus("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFF_80EF, 1'b0);
        applyStimulus("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 0, 32'h0000_0012, 1'b0);
        applyStimulus("lh_13",  1'b0, 3'b001, 32'h13, 32'h0, 0, 32'h0, 1'b1);

        applyStimulus("sw_14",   1'b1, 3'b010, 32'h14, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        applyStimulus("sw_16",   1'b1, 3'b010, 32'h16, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
        applyStimulus("st_f011", 1'b1, 3'b011, 32'h14, 32'h1111_1111, 0, 32'h0, 1'b1);
        applyStimulus("sh_15",   1'b1, 3'b001, 32'h15, 32'h0000_2222, 0, 32'h0, 1'b1);
        applyStimulus("lw_14",   1'b0, 3'b010, 32'h14, 32'h0, 0, 32'h0BAD_F00D, 1'b0);

        applyStimulus("lw_400",  1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h0, 1'b1);
        applyStimulus("sw_3fc",  1'b1, 3'b010, 32'h3FC, 32'h1122_3344, 0, 32'h0, 1'b0);
        applyStimulus("lw_3fc",  1'b0, 3'b010, 32'h3FC, 32'h0, 0, 32'h1122_3344, 1'b0);
        applyStimulus("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1'b1);
        applyStimulus("ld_f110", 1'b0, 3'b110, 32'h10, 32'h0, 0, 32'h0, 1'b1);

        applyStimulus("lw_hold", 1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h1234_80EF, 1'b0);

        applyStimulus("sw_20", 1'b1, 3'b010, 32'h20, 32'h0, 0, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h5555_5555;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        checkOutput("abort_rsp_valid_hold", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
        checkOutput("abort_ready_after", 32'(req_ready), 32'd1);
        applyStimulus("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
